// File: rtl/adder_pkg.sv
// adder_pkg: shared state type and default sizing for the adder result accumulator.
package adder_pkg;
   typedef enum logic {ACC, DONE} acc_state_t;
   localparam int ADDER_DW      = 4;
   localparam int ACC_N_SAMPLES = 4;
   localparam int ACC_W_DEFAULT = 8;
endpackage

// File: rtl/sat_add.sv
// sat_add: unsigned add that clamps to all ones and flags when it does.
module sat_add #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y,
   output logic         sat
);
   logic [W:0] w_sum;
   always_comb begin
      w_sum = {1'b0, a} + {1'b0, b};
      sat   = w_sum[W];
      y     = w_sum[W] ? '1 : w_sum[W-1:0];
   end
endmodule

// File: rtl/adder_result_acc.sv
// adder_result_acc: sums N_SAMPLES {co,sum} adder results into a saturating total
// and offers it on a registered valid/ready port.
module adder_result_acc
   import adder_pkg::*;
#(
   parameter int DW        = ADDER_DW,
   parameter int N_SAMPLES = ACC_N_SAMPLES,
   parameter int ACC_W     = ACC_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW-1:0]    in_sum,
   input  logic             in_co,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic             out_ovf
);
   localparam int CW = $clog2(N_SAMPLES + 1);
   acc_state_t       r_state;
   logic [CW-1:0]    r_cnt;
   logic [ACC_W-1:0] r_acc;
   logic [ACC_W-1:0] r_out_acc;
   logic             r_ovf;
   logic             r_out_ovf;
   logic [ACC_W-1:0] w_v;
   logic [ACC_W-1:0] w_y;
   logic             w_sat;
   logic             w_last;
   assign w_v    = ACC_W'({in_co, in_sum});
   assign w_last = r_cnt == CW'(N_SAMPLES - 1);
   sat_add #(.W(ACC_W)) u_sat (
      .a  (r_acc),
      .b  (w_v),
      .y  (w_y),
      .sat(w_sat)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ACC;
         r_cnt     <= '0;
         r_acc     <= '0;
         r_ovf     <= 1'b0;
         r_out_acc <= '0;
         r_out_ovf <= 1'b0;
      end else if (r_state == ACC) begin
         if (in_valid) begin
            r_acc <= w_y;
            r_ovf <= r_ovf | w_sat;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
               r_state   <= DONE;
               r_out_acc <= w_y;
               r_out_ovf <= r_ovf | w_sat;
            end
         end
      end else if (out_ready) begin
         // out_acc/out_ovf deliberately keep their last values
         r_state <= ACC;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_ovf   <= 1'b0;
      end
   end
   assign in_ready  = r_state == ACC;
   assign out_valid = r_state == DONE;
   assign out_acc   = r_out_acc;
   assign out_ovf   = r_out_ovf;
endmodule

// File: tb/tb_adder_result_acc.sv
// tb_adder_result_acc: directed table plus random traffic on 8-bit and 6-bit
// accumulators, checked against a burst-sum reference model.
module tb_adder_result_acc;
   typedef struct {
      bit vld; bit co; bit [3:0] sum; bit ordy; bit rst;
      bit rdy; bit ov; int acc8; bit ovf8; int acc6; bit ovf6;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [3:0] in_sum = '0;
   logic       in_co = 1'b0;
   logic       out_ready = 1'b0;
   logic       rdy8, ov8, ovf8, rdy6, ov6, ovf6;
   logic [7:0] acc8;
   logic [5:0] acc6;

   int n_cmp = 0;
   int n_bad = 0;
   bit m_pend = 0;
   int m_q[$];
   int m_acc8, m_acc6;
   bit m_ovf8, m_ovf6;
   vec_t tv[$];

   always #5 clk = ~clk;

   adder_result_acc u8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8), .in_sum(in_sum),
      .in_co(in_co), .out_valid(ov8), .out_ready(out_ready), .out_acc(acc8), .out_ovf(ovf8)
   );
   adder_result_acc #(.ACC_W(6)) u6 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy6), .in_sum(in_sum),
      .in_co(in_co), .out_valid(ov6), .out_ready(out_ready), .out_acc(acc6), .out_ovf(ovf6)
   );

   task automatic chk(input string n, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input int vld, co, sum, ordy, r, rdy, ov, a8, o8, a6, o6);
      vec_t v;
      v.vld = vld[0]; v.co = co[0]; v.sum = sum[3:0]; v.ordy = ordy[0]; v.rst = r[0];
      v.rdy = rdy[0]; v.ov = ov[0]; v.acc8 = a8; v.ovf8 = o8[0]; v.acc6 = a6; v.ovf6 = o6[0];
      return v;
   endfunction

   // One clock: drive at negedge, predict the post-edge state, compare after the edge.
   task automatic step(input bit vld, input bit co, input bit [3:0] sum, input bit ordy, input bit r);
      int s;
      @(negedge clk);
      in_valid = vld; in_co = co; in_sum = sum; out_ready = ordy; rst = r;
      if (r) begin
         m_pend = 0; m_q.delete();
      end else if (m_pend) begin
         if (ordy) begin m_pend = 0; m_q.delete(); end
      end else if (vld) begin
         m_q.push_back({co, sum});
         if (m_q.size() == 4) begin
            s = m_q.sum();
            m_acc8 = s > 255 ? 255 : s; m_ovf8 = s > 255;
            m_acc6 = s > 63 ? 63 : s;   m_ovf6 = s > 63;
            m_pend = 1;
         end
      end
      @(posedge clk);
      #1;
      chk("in_ready8", rdy8, !m_pend);
      chk("out_valid8", ov8, m_pend);
      chk("in_ready6", rdy6, !m_pend);
      chk("out_valid6", ov6, m_pend);
      if (m_pend) begin
         chk("out_acc8", acc8, m_acc8);
         chk("out_ovf8", ovf8, m_ovf8);
         chk("out_acc6", acc6, m_acc6);
         chk("out_ovf6", ovf6, m_ovf6);
      end
   endtask

   initial begin
      // accept A,3,2,F then handshake immediately
      tv.push_back(mk(1,0,'hA,1,0, 1,0,0,0,0,0));
      tv.push_back(mk(1,0,3,1,0,   1,0,0,0,0,0));
      tv.push_back(mk(1,0,2,1,0,   1,0,0,0,0,0));
      tv.push_back(mk(1,0,'hF,1,0, 0,1,'h1E,0,'h1E,0));
      tv.push_back(mk(0,0,0,1,0,   1,0,0,0,0,0));
      // four v=31: fits in 8 bits, saturates 6 bits
      for (int i = 0; i < 3; i++) tv.push_back(mk(1,1,'hF,1,0, 1,0,0,0,0,0));
      tv.push_back(mk(1,1,'hF,1,0, 0,1,'h7C,0,'h3F,1));
      tv.push_back(mk(0,0,0,1,0,   1,0,0,0,0,0));
      // sticky overflow cleared by next burst
      for (int i = 0; i < 3; i++) tv.push_back(mk(1,0,1,1,0, 1,0,0,0,0,0));
      tv.push_back(mk(1,0,1,1,0,   0,1,4,0,4,0));
      tv.push_back(mk(0,0,0,1,0,   1,0,0,0,0,0));
      // bubbles 1,0,0,1,1,0,1 with v=2
      tv.push_back(mk(1,0,2,1,0,   1,0,0,0,0,0));
      tv.push_back(mk(0,0,2,1,0,   1,0,0,0,0,0));
      tv.push_back(mk(0,0,2,1,0,   1,0,0,0,0,0));
      tv.push_back(mk(1,0,2,1,0,   1,0,0,0,0,0));
      tv.push_back(mk(1,0,2,1,0,   1,0,0,0,0,0));
      tv.push_back(mk(0,0,2,1,0,   1,0,0,0,0,0));
      tv.push_back(mk(1,0,2,1,0,   0,1,8,0,8,0));
      tv.push_back(mk(0,0,0,1,0,   1,0,0,0,0,0));
      // reset mid-burst discards two accepted 5s
      tv.push_back(mk(1,0,5,1,0,   1,0,0,0,0,0));
      tv.push_back(mk(1,0,5,1,0,   1,0,0,0,0,0));
      tv.push_back(mk(0,0,0,1,1,   1,0,0,0,0,0));
      for (int i = 0; i < 3; i++) tv.push_back(mk(1,0,1,0,0, 1,0,0,0,0,0));
      tv.push_back(mk(1,0,1,0,0,   0,1,4,0,4,0));
      // reset while DONE drops the total without handshake
      tv.push_back(mk(1,0,9,0,1,   1,0,0,0,0,0));

      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      chk("rst_out_acc8", acc8, 0);
      chk("rst_out_ovf8", ovf8, 0);
      chk("rst_out_acc6", acc6, 0);
      chk("rst_out_ovf6", ovf6, 0);

      foreach (tv[i]) begin
         step(tv[i].vld, tv[i].co, tv[i].sum, tv[i].ordy, tv[i].rst);
         chk($sformatf("tv%0d_rdy", i), rdy8, tv[i].rdy);
         chk($sformatf("tv%0d_ov", i), ov8, tv[i].ov);
         if (tv[i].ov) begin
            chk($sformatf("tv%0d_acc8", i), acc8, tv[i].acc8);
            chk($sformatf("tv%0d_ovf8", i), ovf8, tv[i].ovf8);
            chk($sformatf("tv%0d_acc6", i), acc6, tv[i].acc6);
            chk($sformatf("tv%0d_ovf6", i), ovf6, tv[i].ovf6);
         end
      end

      // backpressure: held total must ignore incoming data
      for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) begin
         step(1, 1'($urandom), 4'($urandom), 0, 0);
         chk("bp_acc_hold", acc8, 4);
      end
      step(1, 0, 7, 1, 0);
      chk("bp_ready_after_hs", rdy8, 1);
      step(1, 0, 7, 1, 0);

      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom),
              $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
